computer_system_pio_in_irq: RTL

COMPUTER_SYSTEM_PIO_IN_IRQ -- requirements
Module: computer_system_pio_in_irq

---
 rtl/computer_system_pio_in_irq_if.sv | 26 ++
 rtl/computer_system_pio_in_irq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/computer_system_pio_in_irq_if.sv
// Avalon-MM slave register port for the PIO input block.
// Latency: n/a (signal bundle only).
// Backpressure: none; the slave accepts every access with no wait states.
interface computer_system_pio_in_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/computer_system_pio_in_irq.sv
// PIO input port: synchronised input, edge capture with W1C clear, maskable irq.
// Latency: readdata 1 cycle after address; in_port change visible SYNC_STAGES edges after first capture.
// Backpressure: none; reads and writes complete every cycle, irq is level until cleared or masked.
module computer_system_pio_in_irq #(
    parameter int DATA_WIDTH  = 10,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    computer_system_pio_in_irq_if.slave   bus,
    input  logic [DATA_WIDTH-1:0]         in_port,
    output logic                          irq
);

    // Warm-up spans SYNC_STAGES+1 edges: enough for a value held through
    // reset to reach both data_in and its delayed copy before edges count.
    localparam int WARM_CNT = SYNC_STAGES + 1;
    localparam int CW       = $clog2(WARM_CNT + 1);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_dly_q;
    logic [DATA_WIDTH-1:0] irq_mask_q;
    logic [DATA_WIDTH-1:0] irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_cap_q;
    logic [DATA_WIDTH-1:0] edge_cap_d;
    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_pulse;
    logic [DATA_WIDTH-1:0] clr_mask;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [CW-1:0]         warm_q;
    logic                  warm_done;
    logic                  wr_vld;
    logic [31:0]           rd_d;
    logic [31:0]           rd_q;
    logic                  unused_wdat;

    assign data_in   = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == CW'(WARM_CNT));
    assign wr_vld    = bus.chipselect & ~bus.write_n;
    assign wr_dat    = bus.writedata[DATA_WIDTH-1:0];
    // Bits of writedata above DATA_WIDTH are deliberately ignored.
    assign unused_wdat = &{1'b0, bus.writedata};
    assign bus.readdata = rd_q;

    // Metastability chain: stage 0 samples the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // One-cycle delayed copy of the synchronised data for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_dly_q <= '0;
        end else begin
            data_dly_q <= data_in;
        end
    end

    // Warm-up counter saturates once edge detection is trusted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_q <= '0;
        end else if (!warm_done) begin
            warm_q <= warm_q + CW'(1);
        end
    end

    // Per-bit edge pulse selected by EDGE_TYPE, gated during warm-up.
    always_comb begin
        edge_raw = '0;
        if (EDGE_TYPE == 0) begin
            edge_raw = data_in & ~data_dly_q;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~data_in & data_dly_q;
        end else begin
            edge_raw = data_in ^ data_dly_q;
        end
        edge_pulse = warm_done ? edge_raw : '0;
    end

    // Register-write decode: mask load and W1C clear; a new edge beats a clear.
    always_comb begin
        clr_mask   = '0;
        irq_mask_d = irq_mask_q;
        if (wr_vld && (bus.address == 2'd3)) begin
            clr_mask = wr_dat;
        end
        if (wr_vld && (bus.address == 2'd2)) begin
            irq_mask_d = wr_dat;
        end
        edge_cap_d = (edge_cap_q & ~clr_mask) | edge_pulse;
    end

    // Mask and edge-capture state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    // Read mux, zero-extended; captures pre-update register values.
    always_comb begin
        rd_d = '0;
        case (bus.address)
            2'd0:    rd_d[DATA_WIDTH-1:0] = data_in;
            2'd2:    rd_d[DATA_WIDTH-1:0] = irq_mask_q;
            2'd3:    rd_d[DATA_WIDTH-1:0] = edge_cap_q;
            default: rd_d = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Interrupt straight from registers: level on data or latched edges.
    always_comb begin
        if (IRQ_MODE == 0) begin
            irq = |(data_in & irq_mask_q);
        end else begin
            irq = |(edge_cap_q & irq_mask_q);
        end
    end

endmodule
